// File: rtl/ifetch.sv
// Instruction fetch stage: issues one fetch per cycle to a 1-cycle-latency
// instruction memory and buffers responses in a 2-entry FIFO feeding decode.
module ifetch #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pc,
    input  logic              branch_taken,
    output logic [DATA_W-1:0] imem_addr,
    output logic              imem_en,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              pc_hold,
    output logic [DATA_W-1:0] if_instr,
    output logic [DATA_W-1:0] if_pc,
    output logic              if_valid,
    input  logic              id_ready
);

    logic              req_valid;
    logic [DATA_W-1:0] req_pc;

    logic [DATA_W-1:0] fifo_instr [2];
    logic [DATA_W-1:0] fifo_pc    [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    logic              push;
    logic              pop;
    logic [2:0]        occupancy;

    assign if_valid = (count != 2'd0);
    assign push     = req_valid && !branch_taken;
    assign pop      = if_valid && id_ready && !branch_taken;

    // Slots that will be committed next cycle if nothing new is issued now;
    // stalling at 2 guarantees every issued fetch has a free slot to land in.
    assign occupancy = {1'b0, count} - {2'b00, pop} + {2'b00, req_valid};
    assign pc_hold   = !reset && !branch_taken && (occupancy >= 3'd2);
    assign imem_en   = !reset && !pc_hold;
    assign imem_addr = pc;

    // Head of the buffer comes straight from storage registers.
    assign if_instr = fifo_instr[rd_ptr];
    assign if_pc    = fifo_pc[rd_ptr];

    // Request stage: remember which PC the memory is answering next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_valid <= 1'b0;
            req_pc    <= '0;
        end else begin
            req_valid <= imem_en && !branch_taken;
            if (imem_en) begin
                req_pc <= pc;
            end
        end
    end

    // Buffer stage: capture responses, release to decode in fetch order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else if (branch_taken) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= imem_rdata;
                fifo_pc[wr_ptr]    <= req_pc;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: memory model returns addr ^ 0xDEAD0000 one cycle
// after each request, and a small pc-stage model follows pc_hold / redirects.
module tb_ifetch;

    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        branch_taken;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic        pc_hold;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        id_ready;

    logic [31:0] target;
    logic [31:0] exp_pc;
    int          total;
    int          bad;

    ifetch dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .branch_taken (branch_taken),
        .imem_addr    (imem_addr),
        .imem_en      (imem_en),
        .imem_rdata   (imem_rdata),
        .pc_hold      (pc_hold),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_valid     (if_valid),
        .id_ready     (id_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_addr ^ KEY;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, want);
        end
    endtask

    // One clock: pc-stage model reacts to what it saw before the edge.
    task automatic tick();
        logic h, bt, rs;
        h  = pc_hold;
        bt = branch_taken;
        rs = reset;
        @(posedge clk);
        #1;
        if (rs) pc = 32'h0;
        else if (bt) pc = target;
        else if (!h) pc = pc + 32'd4;
        #1;
    endtask

    // Every handoff to decode must be the next PC in fetch order.
    always @(negedge clk) begin
        if (!reset && !branch_taken && if_valid && id_ready) begin
            chk("order_pc", if_pc, exp_pc);
            chk("order_instr", if_instr, exp_pc ^ KEY);
            exp_pc = exp_pc + 32'd4;
        end
        if (!reset) begin
            chk("no_overflow",
                {31'b0, dut.req_valid && !branch_taken && dut.count == 2'd2 && !(if_valid && id_ready)},
                32'd0);
        end
    end

    initial begin
        total        = 0;
        bad          = 0;
        exp_pc       = 32'h0;
        reset        = 1'b1;
        pc           = 32'h0;
        branch_taken = 1'b0;
        target       = 32'h0;
        id_ready     = 1'b1;
        tick();
        tick();
        chk("rst_imem_en", {31'b0, imem_en}, 32'd0);
        chk("rst_pc_hold", {31'b0, pc_hold}, 32'd0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);

        // Streaming after reset release
        reset = 1'b0;
        #1;
        chk("rel_imem_en", {31'b0, imem_en}, 32'd1);
        chk("rel_imem_addr", imem_addr, 32'h0);
        tick();
        chk("lat1_if_valid", {31'b0, if_valid}, 32'd0);
        tick();
        chk("first_if_valid", {31'b0, if_valid}, 32'd1);
        chk("first_if_pc", if_pc, 32'h0);
        chk("first_if_instr", if_instr, 32'h0 ^ KEY);
        tick();
        chk("stream_pc4", if_pc, 32'h4);
        tick();
        chk("stream_pc8", if_pc, 32'h8);

        // Decode stalls for 5 cycles
        id_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_pc_hold", {31'b0, pc_hold}, 32'd1);
            chk("stall_imem_en", {31'b0, imem_en}, 32'd0);
            chk("stall_if_pc", if_pc, 32'h8);
            tick();
        end
        id_ready = 1'b1;
        #1;
        chk("resume_pc_hold", {31'b0, pc_hold}, 32'd0);
        chk("resume_if_pc8", if_pc, 32'h8);
        tick();
        chk("resume_if_pc12", if_pc, 32'hC);
        tick();
        chk("resume_if_pc16", if_pc, 32'h10);
        tick();
        chk("resume_if_pc20", if_pc, 32'h14);

        // Fill to 2 then toggle id_ready each cycle
        id_ready = 1'b0;
        #1;
        tick();
        for (int i = 0; i < 6; i++) begin
            id_ready = (i % 2 == 0);
            #1;
            chk("toggle_pc_hold", {31'b0, pc_hold}, (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("toggle_if_pc", if_pc, 32'h14 + 32'd4 * 32'((i + 1) / 2));
            tick();
        end

        // Redirect with a full buffer; id_ready asserted but ignored
        branch_taken = 1'b1;
        target       = 32'h40;
        id_ready     = 1'b1;
        #1;
        chk("flush_pc_hold", {31'b0, pc_hold}, 32'd0);
        chk("flush_pre_valid", {31'b0, if_valid}, 32'd1);
        tick();
        branch_taken = 1'b0;
        exp_pc       = 32'h40;
        #1;
        chk("flush_valid_n1", {31'b0, if_valid}, 32'd0);
        chk("flush_imem_addr", imem_addr, 32'h40);
        tick();
        chk("flush_valid_n2", {31'b0, if_valid}, 32'd0);
        tick();
        chk("flush_target_valid", {31'b0, if_valid}, 32'd1);
        chk("flush_target_pc", if_pc, 32'h40);
        tick();
        chk("flush_next_pc", if_pc, 32'h44);

        // Redirect while streaming with a fetch in flight
        branch_taken = 1'b1;
        target       = 32'h100;
        #1;
        tick();
        branch_taken = 1'b0;
        exp_pc       = 32'h100;
        #1;
        chk("flush2_valid_n1", {31'b0, if_valid}, 32'd0);
        tick();
        chk("flush2_valid_n2", {31'b0, if_valid}, 32'd0);
        tick();
        chk("flush2_target_pc", if_pc, 32'h100);
        chk("flush2_target_instr", if_instr, 32'h100 ^ KEY);

        // Reset with a full buffer
        id_ready = 1'b0;
        #1;
        tick();
        chk("prerst_valid", {31'b0, if_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_imem_en", {31'b0, imem_en}, 32'd0);
        chk("midrst_pc_hold", {31'b0, pc_hold}, 32'd0);
        tick();
        chk("midrst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("midrst_if_instr", if_instr, 32'h0);
        chk("midrst_if_pc", if_pc, 32'h0);
        chk("midrst_imem_en2", {31'b0, imem_en}, 32'd0);
        reset    = 1'b0;
        id_ready = 1'b1;
        exp_pc   = 32'h0;
        #1;
        tick();
        tick();
        chk("postrst_valid", {31'b0, if_valid}, 32'd1);
        chk("postrst_pc", if_pc, 32'h0);

        // Reset and redirect together: reset wins
        id_ready = 1'b0;
        #1;
        tick();
        reset        = 1'b1;
        branch_taken = 1'b1;
        target       = 32'h200;
        id_ready     = 1'b1;
        #1;
        chk("both_imem_en", {31'b0, imem_en}, 32'd0);
        chk("both_pc_hold", {31'b0, pc_hold}, 32'd0);
        tick();
        chk("both_if_valid", {31'b0, if_valid}, 32'd0);
        chk("both_if_instr", if_instr, 32'h0);
        chk("both_if_pc", if_pc, 32'h0);
        reset        = 1'b0;
        branch_taken = 1'b0;
        exp_pc       = 32'h0;
        #1;
        chk("both_imem_addr", imem_addr, 32'h0);
        tick();
        tick();
        chk("both_first_pc", if_pc, 32'h0);
        tick();
        tick();
        chk("both_later_pc", if_pc, 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
